// File: rtl/param_cpu.sv
// Parametrised accumulator CPU with Z/C flags, branches, host program load
// and an IDLE/RUN/HALT handshake.
module param_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OPR_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [OPR_W+3:0]  prog_data,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_z,
  output logic              flag_c,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              running,
  output logic              halted
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              ov_q, ov_d;

  logic [OPR_W+3:0]  mem_q [DEPTH];
  logic [OPR_W+3:0]  instr;
  logic [3:0]        op;
  logic [OPR_W-1:0]  opr;
  logic [ADDR_W-1:0] tgt;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [ADDR_W-1:0] pc_inc;

  assign running = (state_q == S_LAUNCH) ||
                   (state_q == S_RUN);
  assign halted  = (state_q == S_HALT);

  always_ff @(posedge clk) begin
    if (prog_we && !running) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign instr  = mem_q[pc_q];
  assign op     = instr[OPR_W+3:OPR_W];
  assign opr    = instr[OPR_W-1:0];
  assign tgt    = opr[ADDR_W-1:0];
  assign pc_inc = pc_q + 1'b1;

  if (OPR_W >= DATA_W) begin : g_trunc
    assign imm = opr[DATA_W-1:0];
  end else begin : g_zext
    assign imm = {{(DATA_W-OPR_W){1'b0}}, opr};
  end

  // MSB of the widened difference is the borrow (acc < imm)
  assign sum  = {1'b0, acc_q} + {1'b0, imm};
  assign diff = {1'b0, acc_q} - {1'b0, imm};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_LAUNCH;
          pc_d    = '0;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        pc_d = pc_inc;
        unique case (op)
          4'h0: ;
          4'h1: begin
            acc_d = imm;
            z_d   = (imm == '0);
          end
          4'h2: begin
            acc_d = sum[DATA_W-1:0];
            z_d   = (sum[DATA_W-1:0] == '0);
            c_d   = sum[DATA_W];
          end
          4'h3: begin
            acc_d = diff[DATA_W-1:0];
            z_d   = (diff[DATA_W-1:0] == '0);
            c_d   = diff[DATA_W];
          end
          4'h4: begin
            acc_d = acc_q & imm;
            z_d   = ((acc_q & imm) == '0);
            c_d   = 1'b0;
          end
          4'h5: begin
            acc_d = acc_q | imm;
            z_d   = ((acc_q | imm) == '0);
            c_d   = 1'b0;
          end
          4'h6: begin
            acc_d = acc_q ^ imm;
            z_d   = ((acc_q ^ imm) == '0);
            c_d   = 1'b0;
          end
          4'h7: begin
            acc_d = {acc_q[DATA_W-2:0], 1'b0};
            z_d   = (acc_q[DATA_W-2:0] == '0);
            c_d   = acc_q[DATA_W-1];
          end
          4'h8: begin
            acc_d = {1'b0, acc_q[DATA_W-1:1]};
            z_d   = (acc_q[DATA_W-1:1] == '0);
            c_d   = acc_q[0];
          end
          4'h9: begin
            z_d = (diff[DATA_W-1:0] == '0);
            c_d = diff[DATA_W];
          end
          4'hA: pc_d = tgt;
          4'hB: if (z_q) pc_d = tgt;
          4'hC: if (!z_q) pc_d = tgt;
          4'hD: if (c_q) pc_d = tgt;
          4'hE: begin
            out_d = acc_q;
            ov_d  = 1'b1;
          end
          4'hF: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  assign acc       = acc_q;
  assign pc        = pc_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign out_data  = out_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_param_cpu.sv
// Randomised bench for param_cpu against an instruction-level ISA model.
module tb_param_cpu;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic [7:0]  acc;
  logic [3:0]  pc;
  logic        flag_z;
  logic        flag_c;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        running;
  logic        halted;

  param_cpu #(.DATA_W(8), .ADDR_W(4), .OPR_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .acc(acc),
    .pc(pc),
    .flag_z(flag_z),
    .flag_c(flag_c),
    .out_data(out_data),
    .out_valid(out_valid),
    .running(running),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [11:0] pmem [16];
  int macc, mpc, mout;
  bit mz, mc, mov, mhalt;
  bit saw_wrap;
  logic [7:0] douts [$];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ins(int op, int opr);
    ins = {4'(op), 8'(opr)};
  endfunction

  task automatic mstep();
    int op, im, nx;
    op = int'(pmem[mpc][11:8]);
    im = int'(pmem[mpc][7:0]);
    nx = (mpc + 1) % 16;
    mov = 0;
    case (op)
      1: begin macc = im; mz = (macc == 0); end
      2: begin
        mc = (macc + im) > 255;
        macc = (macc + im) % 256;
        mz = (macc == 0);
      end
      3: begin
        mc = macc < im;
        macc = (macc - im + 256) % 256;
        mz = (macc == 0);
      end
      4: begin macc = macc & im; mc = 0; mz = (macc == 0); end
      5: begin macc = macc | im; mc = 0; mz = (macc == 0); end
      6: begin macc = macc ^ im; mc = 0; mz = (macc == 0); end
      7: begin
        mc = macc >= 128;
        macc = (macc * 2) % 256;
        mz = (macc == 0);
      end
      8: begin
        mc = (macc % 2) == 1;
        macc = macc / 2;
        mz = (macc == 0);
      end
      9: begin mc = macc < im; mz = (macc == im); end
      10: nx = im % 16;
      11: if (mz) nx = im % 16;
      12: if (!mz) nx = im % 16;
      13: if (mc) nx = im % 16;
      14: begin mout = macc; mov = 1; end
      15: begin mhalt = 1; nx = mpc; end
      default: ;
    endcase
    mpc = nx;
  endtask

  task automatic load(int a, logic [11:0] d);
    prog_we = 1'b1;
    prog_addr = 4'(a);
    prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    pmem[a] = d;
  endtask

  task automatic rand_drive();
    start = 1'($urandom % 2);
    prog_we = 1'($urandom % 2);
    prog_addr = 4'($urandom);
    prog_data = 12'($urandom);
  endtask

  task automatic run(int maxsteps, int wa, logic [11:0] wd);
    int steps;
    int prev_pc;
    douts.delete();
    start = 1'b1;
    if (wa >= 0) begin
      prog_we = 1'b1;
      prog_addr = 4'(wa);
      prog_data = wd;
    end
    @(posedge clk); #1;
    start = 1'b0;
    prog_we = 1'b0;
    if (wa >= 0) pmem[wa] = wd;
    mpc = 0;
    mhalt = 0;
    mov = 0;
    check("launch_state", {running, halted}, 2'b10);
    check("launch_pc", 32'(pc), 0);
    rand_drive();
    @(posedge clk); #1;
    check("bubble_acc", 32'(acc), macc);
    check("bubble_ov", 32'(out_valid), 0);
    steps = 0;
    prev_pc = 0;
    while (!mhalt && steps < maxsteps) begin
      rand_drive();
      mstep();
      if (mhalt) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      prog_we = 1'b0;
      steps++;
      check("acc", 32'(acc), macc);
      check("pc", 32'(pc), mpc);
      check("flags", {flag_z, flag_c}, {mz, mc});
      check("out_valid", 32'(out_valid), 32'(mov));
      check("out_data", 32'(out_data), mout);
      check("state", {running, halted},
            mhalt ? 2'b01 : 2'b10);
      if (out_valid) douts.push_back(out_data);
      if (prev_pc == 15 && pc == 4'd0) saw_wrap = 1;
      prev_pc = int'(pc);
    end
    if (mhalt) begin
      @(posedge clk); #1;
      check("halt_hold", {running, halted, pc},
            {2'b01, 4'(mpc)});
      check("halt_ov", 32'(out_valid), 0);
    end else begin
      reset_n = 1'b0;
      #1;
      check("rst_acc_pc", {acc, pc}, 0);
      check("rst_flags", {flag_z, flag_c, out_valid}, 0);
      check("rst_state", {running, halted, out_data}, 0);
      macc = 0; mz = 0; mc = 0; mout = 0;
      #2;
      reset_n = 1'b1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    macc = 0; mpc = 0; mout = 0;
    mz = 0; mc = 0; mov = 0; mhalt = 0;
    saw_wrap = 0;
    @(posedge clk); #1;
    check("reset_regs", {acc, pc, out_data}, 0);
    check("reset_flags", {flag_z, flag_c, out_valid}, 0);
    check("reset_state", {running, halted}, 0);
    reset_n = 1'b1;

    load(0, ins(1, 8'hF0));
    load(1, ins(2, 8'h20));
    load(2, ins(14, 0));
    load(3, ins(15, 0));
    for (int a = 4; a < 16; a++) load(a, ins(15, 0));
    run(20, -1, 12'h0);
    check("t1_out", 32'(out_data), 32'h10);
    check("t1_c", {flag_c, flag_z, halted}, 3'b101);
    check("t1_pc", 32'(pc), 3);
    check("t1_npulse", douts.size(), 1);

    run(20, -1, 12'h0);
    check("t1_rerun_out", 32'(out_data), 32'h10);

    load(0, ins(1, 3));
    load(1, ins(3, 1));
    load(2, ins(14, 0));
    load(3, ins(12, 1));
    load(4, ins(15, 0));
    run(30, -1, 12'h0);
    check("cd_npulse", douts.size(), 3);
    if (douts.size() == 3) begin
      check("cd_seq", {douts[0], douts[1], douts[2]},
            24'h020100);
    end
    check("cd_end", {acc, flag_z, halted}, {8'h00, 2'b11});

    load(0, ins(1, 8'h81));
    load(1, ins(9, 8'h81));
    load(2, ins(11, 4));
    load(3, ins(1, 0));
    load(4, ins(8, 0));
    load(5, ins(14, 0));
    load(6, ins(15, 0));
    run(30, -1, 12'h0);
    check("cs_acc", {acc, flag_c}, {8'h40, 1'b1});
    check("cs_out", 32'(out_data), 32'h40);

    for (int a = 0; a < 15; a++) load(a, ins(0, 0));
    load(15, ins(2, 1));
    load(0, ins(2, 1));
    run(20, -1, 12'h0);
    check("wrap_seen", 32'(saw_wrap), 1);

    for (int it = 0; it < 30; it++) begin
      if ($urandom % 4 != 0) begin
        for (int a = 0; a < 16; a++) load(a, 12'($urandom));
      end
      if ($urandom % 2 == 1) run(40, int'($urandom % 16), 12'($urandom));
      else run(40, -1, 12'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
